// File: rtl/ins_fetch_pkg.sv
// Shared types and constants for the instruction fetcher: FSM encoding, queue entry, PC steps.
package ins_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        compressed;
    } ins_entry_t;

    localparam logic [31:0] PC_INC_HALF = 32'd2;
    localparam logic [31:0] PC_INC_WORD = 32'd4;

    function automatic logic is_compressed(input logic [31:0] ins);
        return ins[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/ins_queue.sv
// Synchronous instruction FIFO with clear, full/empty flags and occupancy count.
module ins_queue
    import ins_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             clr,
    input  logic             wr_en,
    input  ins_entry_t       wr_data,
    input  logic             rd_en,
    output ins_entry_t       rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    ins_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    assign full    = count_q == CNT_W'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally
            wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
            rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
            count_d  = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_wr && !clr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/ins_fetcher.sv
// Instruction fetcher: issues one fetch at a time, queues results for the decoder, handles redirects.
// Optional macro INSFETCH_BYPASS_EN forwards done data straight to ins_* when the queue is empty.
module ins_fetcher
    import ins_fetch_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        flush_pipline,
    input  logic [31:0] flush_pc,
    output logic        try_start_insfetch_task,
    output logic [31:0] insfetch_addr,
    input  logic        insfetch_task_done,
    input  logic [31:0] insfetch_ins_full,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_out,
    output logic [31:0] ins_pc,
    output logic        ins_is_compressed
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             req_q, req_d;
    logic [31:0]      addr_q, addr_d;
    logic             q_push, q_pop, q_clr, q_full, q_empty;
    logic [CNT_W-1:0] q_count;
    ins_entry_t       q_head, new_entry, head;
    logic             accept, can_issue;

    ins_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clr      (q_clr),
        .wr_en    (q_push),
        .wr_data  (new_entry),
        .rd_en    (q_pop),
        .rd_data  (q_head),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count)
    );

    assign can_issue = (q_count < CNT_W'(QUEUE_DEPTH)) && !flush_pipline;
    assign accept    = rdy_in && (state_q == ST_WAIT) && insfetch_task_done && !flush_pipline;
    assign new_entry = '{ins: insfetch_ins_full, pc: fetch_pc_q,
                         compressed: is_compressed(insfetch_ins_full)};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
        end
    end

    // done takes precedence over flush for the state: the response has landed either way
    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            unique case (state_q)
                ST_IDLE:  if (can_issue) state_d = ST_WAIT;
                ST_WAIT:  if (insfetch_task_done) state_d = ST_IDLE;
                          else if (flush_pipline) state_d = ST_DRAIN;
                ST_DRAIN: if (insfetch_task_done) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        q_clr      = 1'b0;
        q_pop      = 1'b0;
        q_push     = 1'b0;
        if (rdy_in) begin
            if (state_q == ST_IDLE && state_d == ST_WAIT) begin
                req_d  = 1'b1;
                addr_d = fetch_pc_q;
            end else if (state_d == ST_IDLE) begin
                req_d = 1'b0;
            end
            if (flush_pipline) begin
                fetch_pc_d = flush_pc;
                q_clr      = 1'b1;
            end else if (accept) begin
                fetch_pc_d = fetch_pc_q + (new_entry.compressed ? PC_INC_HALF : PC_INC_WORD);
            end
            q_pop = !q_empty && ins_ready && !flush_pipline;
        end
`ifdef INSFETCH_BYPASS_EN
        // Empty queue: show the arriving word now, store it only if the decoder did not take it
        head      = q_empty ? (accept ? new_entry : '0) : q_head;
        ins_valid = !q_empty || accept;
        q_push    = accept && !q_full && !(q_empty && ins_ready);
`else
        head      = q_empty ? '0 : q_head;
        ins_valid = !q_empty;
        q_push    = accept && !q_full;
`endif
        try_start_insfetch_task = req_q;
        insfetch_addr           = addr_q;
        ins_out                 = head.ins;
        ins_pc                  = head.pc;
        ins_is_compressed       = head.compressed;
    end

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed vector bench for ins_fetcher (default build, QUEUE_DEPTH=4, RESET_PC=0).
module tb_ins_fetcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        flush;
    logic [31:0] fpc;
    logic        req;
    logic [31:0] addr;
    logic        done;
    logic [31:0] ins_in;
    logic        vld;
    logic        ready;
    logic [31:0] out;
    logic [31:0] pc;
    logic        cmp;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rdy;
        logic        fl;
        logic [31:0] fpc;
        logic        dn;
        logic [31:0] ins;
        logic        rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_out;
        logic [31:0] e_pc;
        logic        e_c;
    } vec_t;

    vec_t vecs[$];

    ins_fetcher #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_in                  (clk),
        .rst_n_in                (rst_n),
        .rdy_in                  (rdy),
        .flush_pipline           (flush),
        .flush_pc                (fpc),
        .try_start_insfetch_task (req),
        .insfetch_addr           (addr),
        .insfetch_task_done      (done),
        .insfetch_ins_full       (ins_in),
        .ins_valid               (vld),
        .ins_ready               (ready),
        .ins_out                 (out),
        .ins_pc                  (pc),
        .ins_is_compressed       (cmp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_vld, input logic [31:0] e_out,
                            input logic [31:0] e_pc, input logic e_c);
        chk({tag, ".req"},   32'(req),  32'(e_req));
        chk({tag, ".addr"},  addr,      e_addr);
        chk({tag, ".valid"}, 32'(vld),  32'(e_vld));
        chk({tag, ".ins"},   out,       e_out);
        chk({tag, ".pc"},    pc,        e_pc);
        chk({tag, ".cmp"},   32'(cmp),  32'(e_c));
        $display("%s: req=%0b addr=%h valid=%0b ins=%h pc=%h c=%0b",
                 tag, req, addr, vld, out, pc, cmp);
    endtask

    task automatic add(input logic r, input logic f, input logic [31:0] fp, input logic d,
                       input logic [31:0] i, input logic rd, input logic eq,
                       input logic [31:0] ea, input logic ev, input logic [31:0] eo,
                       input logic [31:0] ep, input logic ec);
        vec_t v;
        v = '{rdy: r, fl: f, fpc: fp, dn: d, ins: i, rd: rd, e_req: eq, e_addr: ea,
              e_vld: ev, e_out: eo, e_pc: ep, e_c: ec};
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        //   rdy fl fpc       dn ins           rd | req addr      vld out           pc        c
        add(1, 0, 32'h0,   0, 32'h0,        0,   1, 32'h0,    0, 32'h0,        32'h0,    0); // 0 first request
        add(1, 0, 32'h0,   1, 32'h00500093, 0,   0, 32'h0,    1, 32'h00500093, 32'h0,    0); // 1
        add(1, 0, 32'h0,   0, 32'h0,        0,   1, 32'h4,    1, 32'h00500093, 32'h0,    0); // 2
        add(1, 0, 32'h0,   1, 32'h00004501, 1,   0, 32'h4,    1, 32'h00004501, 32'h4,    1); // 3 push+pop
        add(1, 0, 32'h0,   0, 32'h0,        1,   1, 32'h6,    0, 32'h0,        32'h0,    0); // 4
        add(1, 0, 32'h0,   1, 32'h00000013, 0,   0, 32'h6,    1, 32'h00000013, 32'h6,    0); // 5
        add(1, 0, 32'h0,   0, 32'h0,        0,   1, 32'hA,    1, 32'h00000013, 32'h6,    0); // 6
        add(1, 0, 32'h0,   1, 32'h00000001, 0,   0, 32'hA,    1, 32'h00000013, 32'h6,    0); // 7
        add(1, 0, 32'h0,   0, 32'h0,        0,   1, 32'hC,    1, 32'h00000013, 32'h6,    0); // 8
        add(1, 0, 32'h0,   1, 32'h00108093, 0,   0, 32'hC,    1, 32'h00000013, 32'h6,    0); // 9
        add(1, 0, 32'h0,   0, 32'h0,        0,   1, 32'h10,   1, 32'h00000013, 32'h6,    0); // 10
        add(1, 0, 32'h0,   1, 32'h00208113, 0,   0, 32'h10,   1, 32'h00000013, 32'h6,    0); // 11 queue full
        add(1, 0, 32'h0,   0, 32'h0,        0,   0, 32'h10,   1, 32'h00000013, 32'h6,    0); // 12 no request
        add(1, 0, 32'h0,   0, 32'h0,        0,   0, 32'h10,   1, 32'h00000013, 32'h6,    0); // 13
        add(1, 0, 32'h0,   0, 32'h0,        1,   0, 32'h10,   1, 32'h00000001, 32'hA,    1); // 14 pop
        add(1, 0, 32'h0,   0, 32'h0,        0,   1, 32'h14,   1, 32'h00000001, 32'hA,    1); // 15 resumes
        add(1, 1, 32'h100, 0, 32'h0,        0,   1, 32'h14,   0, 32'h0,        32'h0,    0); // 16 flush->DRAIN
        add(1, 0, 32'h0,   0, 32'h0,        0,   1, 32'h14,   0, 32'h0,        32'h0,    0); // 17
        add(1, 0, 32'h0,   1, 32'h00300193, 0,   0, 32'h14,   0, 32'h0,        32'h0,    0); // 18 discarded
        add(1, 0, 32'h0,   0, 32'h0,        0,   1, 32'h100,  0, 32'h0,        32'h0,    0); // 19
        add(1, 0, 32'h0,   1, 32'h00400213, 0,   0, 32'h100,  1, 32'h00400213, 32'h100,  0); // 20
        add(1, 0, 32'h0,   0, 32'h0,        0,   1, 32'h104,  1, 32'h00400213, 32'h100,  0); // 21
        add(1, 1, 32'h100, 1, 32'h00500293, 0,   0, 32'h104,  0, 32'h0,        32'h0,    0); // 22 flush+done
        add(1, 0, 32'h0,   0, 32'h0,        0,   1, 32'h100,  0, 32'h0,        32'h0,    0); // 23
        add(1, 0, 32'h0,   1, 32'h00600313, 0,   0, 32'h100,  1, 32'h00600313, 32'h100,  0); // 24
        add(0, 1, 32'h300, 1, 32'hFFFFFFFF, 1,   0, 32'h100,  1, 32'h00600313, 32'h100,  0); // 25 frozen
        add(0, 1, 32'h300, 1, 32'hFFFFFFFF, 1,   0, 32'h100,  1, 32'h00600313, 32'h100,  0); // 26
        add(0, 1, 32'h300, 1, 32'hFFFFFFFF, 1,   0, 32'h100,  1, 32'h00600313, 32'h100,  0); // 27
        add(1, 0, 32'h0,   0, 32'h0,        1,   1, 32'h104,  0, 32'h0,        32'h0,    0); // 28
        add(0, 0, 32'h0,   1, 32'h00000011, 0,   1, 32'h104,  0, 32'h0,        32'h0,    0); // 29 frozen WAIT
        add(1, 0, 32'h0,   1, 32'h00700393, 0,   0, 32'h104,  1, 32'h00700393, 32'h104,  0); // 30
        add(1, 0, 32'h0,   0, 32'h0,        0,   1, 32'h108,  1, 32'h00700393, 32'h104,  0); // 31

        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; fpc = '0;
        done = 1'b0; ins_in = '0; ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_outs("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0);
        rst_n = 1'b1;
        #1;
        chk("release.req_before_edge", 32'(req), 32'h0);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            rdy = vecs[i].rdy; flush = vecs[i].fl; fpc = vecs[i].fpc;
            done = vecs[i].dn; ins_in = vecs[i].ins; ready = vecs[i].rd;
            @(posedge clk);
            @(negedge clk);
            chk_outs($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld,
                     vecs[i].e_out, vecs[i].e_pc, vecs[i].e_c);
        end
        rdy = 1'b1; flush = 1'b0; done = 1'b0; ready = 1'b0;

        // Asynchronous reset while a request is outstanding
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 0, 32'h0, 0, 32'h0, 32'h0, 0);
        @(negedge clk);
        chk_outs("rst_held", 0, 32'h0, 0, 32'h0, 32'h0, 0);
        rst_n = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end while (!req && cyc < 8);
        chk("restart.latency", 32'(cyc), 32'd1);
        chk_outs("restart", 1, 32'h0, 0, 32'h0, 32'h0, 0);
        done = 1'b1; ins_in = 32'h00500093;
        @(posedge clk);
        @(negedge clk);
        done = 1'b0; ins_in = '0;
        chk_outs("restart_done", 0, 32'h0, 1, 32'h00500093, 32'h0, 0);
        @(posedge clk);
        @(negedge clk);
        chk_outs("restart_next", 1, 32'h4, 1, 32'h00500093, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ins_fetcher.md
INS_FETCHER -- requirements
Module: ins_fetcher

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, meaning instruction queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, meaning first fetch address after reset.
REQ-003 SHALL have port clk_in  input  1  system clock; the block uses one clock.
REQ-004 SHALL have port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy_in  input  1  global ready; low freezes all state.
REQ-006 SHALL have port flush_pipline  input  1  redirect request.
REQ-007 SHALL have port flush_pc  input  32  redirect target, sampled with flush_pipline.
REQ-008 SHALL have port try_start_insfetch_task  output  1  fetch request to memory adapter.
REQ-009 SHALL have port insfetch_addr  output  32  fetch address.
REQ-010 SHALL have port insfetch_task_done  input  1  one-cycle completion pulse.
REQ-011 SHALL have port insfetch_ins_full  input  32  fetched instruction, valid only while done is high.
REQ-012 SHALL have port ins_valid  output  1  queue head valid to decoder.
REQ-013 SHALL have port ins_ready  input  1  decoder accepts head.
REQ-014 SHALL have port ins_out  output  32  head instruction.
REQ-015 SHALL have port ins_pc  output  32  head instruction PC.
REQ-016 SHALL have port ins_is_compressed  output  1  head is 16-bit (bits[1:0] != 2'b11).

Function
REQ-017 SHALL run FSM states IDLE, WAIT, DRAIN.
REQ-018 SHALL go IDLE->WAIT with try_start_insfetch_task=1 and insfetch_addr=fetch_pc only when the queue holds fewer than QUEUE_DEPTH entries and no flush is present.
REQ-019 SHALL hold try_start_insfetch_task and insfetch_addr stable throughout WAIT until insfetch_task_done.
REQ-020 SHALL, on done in WAIT, push {insfetch_ins_full, fetch_pc, compressed}, advance fetch_pc by 2 if insfetch_ins_full[1:0]!=2'b11 else by 4 (32-bit wrap), and return to IDLE.
REQ-021 SHALL pop the head when ins_valid && ins_ready; push and pop in one cycle leaves count unchanged.
REQ-022 SHALL, on flush_pipline, empty the queue, drop ins_valid next cycle, and load fetch_pc<=flush_pc.
REQ-023 SHALL, on flush while in WAIT without done, enter DRAIN, keep the request asserted until done, discard that data, then go IDLE.
REQ-024 SHALL give flush priority over a coincident done: data discarded, state IDLE, fetch_pc=flush_pc.
REQ-025 SHALL, with rdy_in low, perform no push, pop, PC update or state change, and hold all outputs.
REQ-026 SHALL issue the first request in the first cycle after reset release, with registered-path latency done->ins_valid of 1 cycle.

Reset
REQ-027 SHALL on rst_n_in low immediately set state=IDLE, fetch_pc=RESET_PC, queue count=0, ins_valid=0, try_start_insfetch_task=0, insfetch_addr=0, ins_out=0, ins_pc=0, ins_is_compressed=0.
REQ-028 SHALL, if reset asserts mid-WAIT, forget the outstanding request; the adapter is reset by the same event.

Configuration
REQ-029 SHALL, with INSFETCH_BYPASS_EN defined, present done data combinationally on ins_* when the queue is empty, without storing it if ins_ready is high the same cycle (0-cycle latency).
REQ-030 SHALL, without INSFETCH_BYPASS_EN, always register fetched data into the queue (1-cycle latency).

Structure
REQ-031 SHALL place the FSM state encoding, queue entry typedef {ins, pc, compressed}, and PC increment constants 2/4 in package ins_fetch_pkg.
REQ-032 SHALL implement storage as sub-module ins_queue (synchronous FIFO with clear, full/empty, count).

Verification
REQ-033 SHALL test reset release: RESET_PC=0 -> cycle 1 request addr 0x0; done with 0x00500093 -> ins_valid, ins_pc=0, next addr 0x4.
REQ-034 SHALL test compressed: done with 0x00004501 at pc 0x4 -> ins_is_compressed=1, next addr 0x6.
REQ-035 SHALL test backpressure: ins_ready=0, 4 dones -> count=4, try_start low; one pop -> request resumes.
REQ-036 SHALL test flush in WAIT: flush_pc=0x100 -> DRAIN, next done discarded, next request addr 0x100, ins_valid=0 until new data.
REQ-037 SHALL test flush coincident with done plus rdy_in low: data dropped, addr 0x100; rdy_in=0 for 3 cycles -> all outputs unchanged.
REQ-038 SHALL test async reset mid-WAIT -> outputs zero immediately, restart at RESET_PC.
